// File: rtl/adder_tree_operand_loader.sv
// Serial-to-parallel operand loader feeding an 8-input registered adder tree.
// Optional frame/short-frame statistics counters when ADDER_LOADER_STATS_EN is defined.
module adder_tree_operand_loader #(
    parameter int WIDTH = 6,
    parameter int LANES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH-1:0]     out_bus,
    output logic [$clog2(LANES+1)-1:0] out_cnt,
`ifdef ADDER_LOADER_STATS_EN
    output logic [15:0]                frame_cnt,
    output logic [15:0]                short_cnt,
`endif
    output logic                       out_short
);

    localparam int IDX_W = $clog2(LANES);
    localparam int CNT_W = $clog2(LANES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic [WIDTH-1:0]         r_buf [LANES];
    logic [LANES*WIDTH-1:0]   w_buf_flat;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_short;
    logic                     r_out_valid;
    logic [LANES*WIDTH-1:0]   r_out_bus;
    logic [CNT_W-1:0]         r_out_cnt;
    logic                     r_out_short;

    logic w_accept;
    logic w_close;
    logic w_load;

    assign s_ready  = rst_n && (r_state == FILL);
    assign w_accept = s_valid && s_ready;
    assign w_close  = w_accept && (s_last || (r_idx == LAST_IDX));
    // The output slot is free when empty or being drained this same cycle.
    assign w_load   = (r_state == FULL) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_close) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (w_load) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_short <= 1'b0;
        end else if (w_load) begin
            r_idx <= '0;
        end else if (w_accept) begin
            if (w_close) begin
                r_cnt   <= CNT_W'(r_idx) + CNT_W'(1);
                r_short <= (r_idx != LAST_IDX);
            end
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Lanes not written before an early s_last keep their cleared zero as padding.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_buf[gi] <= '0;
                end else if (w_load) begin
                    r_buf[gi] <= '0;
                end else if (w_accept && (r_idx == IDX_W'(gi))) begin
                    r_buf[gi] <= s_data;
                end
            end
            assign w_buf_flat[gi*WIDTH +: WIDTH] = r_buf[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
            r_out_cnt   <= '0;
            r_out_short <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_bus   <= w_buf_flat;
            r_out_cnt   <= r_cnt;
            r_out_short <= r_short;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bus   = r_out_bus;
    assign out_cnt   = r_out_cnt;
    assign out_short = r_out_short;

`ifdef ADDER_LOADER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_short_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_short_cnt <= '0;
        end else if (w_load) begin
            if (r_frame_cnt != 16'hFFFF) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (r_short && (r_short_cnt != 16'hFFFF)) begin
                r_short_cnt <= r_short_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign short_cnt = r_short_cnt;
`endif

endmodule
